// File: rtl/param_datapath.sv
// param_datapath: NUM_REGS x DATA_W register file, operand muxes, ALU with
// registered Z/N/C/V flags and an iterative shift-add multiplier behind a valid/ready port.
module param_datapath #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic              writeEnable,
  input  logic              writeSourceSelect,
  input  logic              muxASelect,
  input  logic              muxBSelect,
  input  logic [DATA_W-1:0] extInputData,
  input  logic [ADDR_W-1:0] destAddress,
  input  logic [ADDR_W-1:0] aAddress,
  input  logic [ADDR_W-1:0] bAddress,
  input  logic [3:0]        aluOpCode,
  output logic              busy,
  output logic              done,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] RLast_out
);

  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNTW = $clog2(DATA_W + 1);
  localparam int MSB  = DATA_W - 1;

  localparam logic [CNTW-1:0]   LASTBIT = CNTW'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_PASA = 4'd8;
  localparam logic [3:0] OP_PASB = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } stateT;

  stateT state;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [DATA_W-1:0] rdA;
  logic [DATA_W-1:0] rdB;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] addOp;
  logic [DATA_W:0]   sumW;
  logic [DATA_W:0]   diffW;
  logic [DATA_W-1:0] aluRes;
  logic              aluC;
  logic              aluV;
  logic [DATA_W-1:0] wrData;

  logic [DATA_W-1:0] mulA;
  logic [DATA_W-1:0] mulB;
  logic [DATA_W-1:0] mulAcc;
  logic [DATA_W-1:0] mulSum;
  logic [CNTW-1:0]   mulCnt;
  logic [ADDR_W-1:0] mulDest;
  logic              mulWe;
  logic              lastIter;

  logic              accept;
  logic              startMul;
  logic              regWe;
  logic [ADDR_W-1:0] regAddr;
  logic [DATA_W-1:0] regData;

  function automatic logic inRange(
    input logic [ADDR_W-1:0] a
  );
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  function automatic logic [1:0] zn(
    input logic [DATA_W-1:0] r
  );
    return {r == '0, r[MSB]};
  endfunction

  // Unimplemented addresses read as zero.
  assign rdA = inRange(aAddress)
             ? regs[aAddress[IDXW-1:0]] : '0;
  assign rdB = inRange(bAddress)
             ? regs[bAddress[IDXW-1:0]] : '0;

  assign opA = muxASelect ? extInputData : rdA;
  assign opB = muxBSelect ? extInputData : rdB;

  assign RLast_out = regs[NUM_REGS-1];

  assign accept   = inValid & inReady;
  assign startMul = accept & ~writeSourceSelect
                  & (aluOpCode == OP_MUL);

  // INC/DEC reuse the add/sub paths with a constant one.
  assign addOp = ((aluOpCode == OP_INC) ||
                  (aluOpCode == OP_DEC)) ? ONE : opB;

  assign sumW  = {1'b0, opA} + {1'b0, addOp};
  assign diffW = {1'b0, opA} - {1'b0, addOp};

  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    unique case (aluOpCode)
      OP_ADD, OP_INC: begin
        aluRes = sumW[MSB:0];
        aluC   = sumW[DATA_W];
        aluV   = (opA[MSB] == addOp[MSB]) &&
                 (aluRes[MSB] != opA[MSB]);
      end
      OP_SUB, OP_DEC: begin
        aluRes = diffW[MSB:0];
        aluC   = diffW[DATA_W];
        aluV   = (opA[MSB] != addOp[MSB]) &&
                 (aluRes[MSB] != opA[MSB]);
      end
      OP_AND:  aluRes = opA & opB;
      OP_OR:   aluRes = opA | opB;
      OP_XOR:  aluRes = opA ^ opB;
      OP_NOT:  aluRes = ~opA;
      OP_SHL: begin
        aluRes = {opA[MSB-1:0], 1'b0};
        aluC   = opA[MSB];
      end
      OP_SHR: begin
        aluRes = {1'b0, opA[MSB:1]};
        aluC   = opA[0];
      end
      OP_PASA: aluRes = opA;
      OP_PASB: aluRes = opB;
      default: aluRes = '0;
    endcase
  end

  assign wrData = writeSourceSelect ? extInputData : aluRes;

  assign mulSum   = mulAcc + (mulB[0] ? mulA : '0);
  assign lastIter = (mulCnt == LASTBIT);

  // One write port shared by single-cycle retire and MUL completion.
  always_comb begin
    regWe   = 1'b0;
    regAddr = destAddress;
    regData = wrData;
    if (state == ST_MUL) begin
      regWe   = mulWe & lastIter;
      regAddr = mulDest;
      regData = mulSum;
    end else if (accept && !startMul) begin
      regWe = writeEnable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (regWe && inRange(regAddr)) begin
      regs[regAddr[IDXW-1:0]] <= regData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      inReady <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      flags   <= '0;
      mulA    <= '0;
      mulB    <= '0;
      mulAcc  <= '0;
      mulCnt  <= '0;
      mulDest <= '0;
      mulWe   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (startMul) begin
            mulA    <= opA;
            mulB    <= opB;
            mulAcc  <= '0;
            mulCnt  <= '0;
            mulDest <= destAddress;
            mulWe   <= writeEnable;
            state   <= ST_MUL;
            busy    <= 1'b1;
            inReady <= 1'b0;
          end else if (accept) begin
            done <= 1'b1;
            if (!writeSourceSelect) begin
              flags <= {zn(aluRes), aluC, aluV};
            end
          end
        end
        ST_MUL: begin
          mulAcc <= mulSum;
          mulA   <= {mulA[MSB-1:0], 1'b0};
          mulB   <= {1'b0, mulB[MSB:1]};
          mulCnt <= mulCnt + CNTW'(1);
          if (lastIter) begin
            flags   <= {zn(mulSum), 2'b00};
            done    <= 1'b1;
            busy    <= 1'b0;
            inReady <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath: 8-bit/16-reg and 16-bit/12-reg
// instances against an arithmetic reference model.
module tb_param_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst8, valid, wEn, wSrc, mA, mB;
  logic [7:0] ext;
  logic [3:0] dest, aAd, bAd, op;
  logic       rdy, busy, done;
  logic [3:0] flags;
  logic [7:0] rlast;

  param_datapath dut8 (
    .clk(clk), .rst(rst8), .inValid(valid), .inReady(rdy),
    .writeEnable(wEn), .writeSourceSelect(wSrc),
    .muxASelect(mA), .muxBSelect(mB), .extInputData(ext),
    .destAddress(dest), .aAddress(aAd), .bAddress(bAd),
    .aluOpCode(op), .busy(busy), .done(done), .flags(flags),
    .RLast_out(rlast)
  );

  logic        rst16, v16, we16, src16, ma16, mb16;
  logic [15:0] ext16;
  logic [3:0]  d16, a16, b16, op16;
  logic        rdy16, busy16, done16;
  logic [3:0]  fl16;
  logic [15:0] rl16;

  param_datapath #(.DATA_W(16), .NUM_REGS(12), .ADDR_W(4)) dut16 (
    .clk(clk), .rst(rst16), .inValid(v16), .inReady(rdy16),
    .writeEnable(we16), .writeSourceSelect(src16),
    .muxASelect(ma16), .muxBSelect(mb16), .extInputData(ext16),
    .destAddress(d16), .aAddress(a16), .bAddress(b16),
    .aluOpCode(op16), .busy(busy16), .done(done16), .flags(fl16),
    .RLast_out(rl16)
  );

  // Reference state of the 8-bit instance
  int         mReg [16];
  logic [3:0] mFlags;
  int         pRes;
  int         pDest;
  bit         pWe;
  logic [3:0] pFlags;

  function automatic void refAlu(
    input int w, input int o, input longint a, input longint b,
    output longint r, output logic [3:0] f
  );
    longint m, h, sa, sb;
    logic c, v;
    m = (longint'(1) << w) - 1;
    h = longint'(1) << (w - 1);
    sa = (a >= h) ? a - (m + 1) : a;
    sb = (b >= h) ? b - (m + 1) : b;
    c = 1'b0;
    v = 1'b0;
    case (o)
      0: begin r = a + b; c = (r > m); v = (sa + sb >= h) || (sa + sb < -h); end
      1: begin r = a - b; c = (a < b); v = (sa - sb >= h) || (sa - sb < -h); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin r = a * 2; c = (a >= h); end
      7: begin r = a / 2; c = (a % 2 == 1); end
      8: r = a;
      9: r = b;
      10: r = a * b;
      11: begin r = a + 1; c = (a == m); v = (sa == h - 1); end
      12: begin r = a - 1; c = (a == 0); v = (sa == -h); end
      default: r = 0;
    endcase
    r = r & m;
    f = {r == 0, r >= h, c, v};
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) mReg[i] = 0;
    mFlags = 4'b0000;
  endfunction

  task automatic drive8(input int o, input bit src, input bit we,
                        input bit sa, input bit sb, input int e,
                        input int d, input int ra, input int rb);
    op = o[3:0]; wSrc = src; wEn = we; mA = sa; mB = sb;
    ext = e[7:0]; dest = d[3:0]; aAd = ra[3:0]; bAd = rb[3:0];
    valid = 1'b1;
  endtask

  // Single-cycle instruction: one accepting edge, then model update.
  task automatic issue(input int o, input bit src, input bit we,
                       input bit sa, input bit sb, input int e,
                       input int d, input int ra, input int rb);
    longint r;
    logic [3:0] f;
    refAlu(8, o, sa ? e : mReg[ra], sb ? e : mReg[rb], r, f);
    drive8(o, src, we, sa, sb, e, d, ra, rb);
    @(posedge clk); #1;
    valid = 1'b0;
    if (!src) mFlags = f;
    if (we) mReg[d] = src ? (e & 255) : int'(r);
  endtask

  task automatic startMul(input bit we, input bit sa, input bit sb,
                          input int e, input int d, input int ra, input int rb);
    longint r;
    logic [3:0] f;
    refAlu(8, 10, sa ? e : mReg[ra], sb ? e : mReg[rb], r, f);
    pRes = int'(r); pDest = d; pWe = we; pFlags = f;
    drive8(10, 1'b0, we, sa, sb, e, d, ra, rb);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic waitReady(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 40);
  endtask

  function automatic void finishMul();
    mFlags = pFlags;
    if (pWe) mReg[pDest] = pRes;
  endfunction

  task automatic test_reset();
    rst8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0;
    modelReset();
    checks++;
    if (rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: rdy/busy/done got %b%b%b want 100", rdy, busy, done);
    end
    checks++;
    if (flags !== 4'b0000 || rlast !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: flags %b rlast %h want 0000 00", flags, rlast);
    end
  endtask

  task automatic test_loads();
    issue(0, 1, 1, 0, 0, 'h7F, 1, 0, 0);
    checks++;
    if (done !== 1'b1 || flags !== 4'b0000 || rlast !== 8'h00) begin
      errors++;
      $display("FAIL load_r1: done %b flags %b rlast %h want 1 0000 00", done, flags, rlast);
    end
    issue(0, 1, 1, 0, 0, 'h01, 2, 0, 0);
    checks++;
    if (done !== 1'b1 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL load_r2: done %b flags %b want 1 0000", done, flags);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_drop: got %b want 0", done);
    end
  endtask

  task automatic test_arith();
    issue(0, 0, 1, 0, 0, 0, 3, 1, 2);
    checks++;
    if (flags !== 4'b0101 || flags !== mFlags) begin
      errors++;
      $display("FAIL add_flags: got %b want 0101", flags);
    end
    issue(1, 0, 1, 0, 0, 0, 4, 2, 1);
    checks++;
    if (flags !== 4'b0110 || flags !== mFlags) begin
      errors++;
      $display("FAIL sub_flags: got %b want 0110", flags);
    end
    issue(8, 0, 1, 0, 0, 0, 15, 3, 0);
    checks++;
    if (rlast !== 8'h80 || rlast !== mReg[3][7:0]) begin
      errors++;
      $display("FAIL add_r3: got %h want 80", rlast);
    end
    issue(8, 0, 1, 0, 0, 0, 15, 4, 0);
    checks++;
    if (rlast !== 8'h82 || flags !== mFlags) begin
      errors++;
      $display("FAIL sub_r4: got %h/%b want 82/%b", rlast, flags, mFlags);
    end
  endtask

  task automatic test_back_to_back();
    issue(0, 1, 1, 0, 0, 'h55, 15, 0, 0);
    checks++;
    if (rlast !== 8'h55 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load: rlast %h done %b want 55 1", rlast, done);
    end
    issue(8, 0, 1, 0, 0, 0, 5, 15, 0);
    checks++;
    if (done !== 1'b1 || flags !== mFlags) begin
      errors++;
      $display("FAIL b2b_pass: done %b flags %b want 1 %b", done, flags, mFlags);
    end
    // Reads R15 while overwriting it: old value feeds the adder.
    issue(0, 0, 1, 0, 1, 'h11, 15, 15, 0);
    checks++;
    if (rlast !== 8'h66 || flags !== mFlags) begin
      errors++;
      $display("FAIL same_cycle_rw: rlast %h want 66", rlast);
    end
    issue(8, 0, 1, 0, 0, 0, 15, 5, 0);
    checks++;
    if (rlast !== 8'h55 || rlast !== mReg[5][7:0]) begin
      errors++;
      $display("FAIL b2b_r5: got %h want 55", rlast);
    end
  endtask

  task automatic test_mul();
    int n;
    issue(0, 1, 1, 0, 0, 'h0D, 6, 0, 0);
    issue(0, 1, 1, 0, 0, 'h0B, 7, 0, 0);
    startMul(1, 0, 0, 0, 15, 6, 7);
    checks++;
    if (rdy !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mul_start: rdy/busy/done %b%b%b want 010", rdy, busy, done);
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 2) drive8(0, 1, 1, 0, 0, 'hAA, 15, 0, 0);
      if (n == 3) valid = 1'b0;
    end while (!rdy && n < 40);
    finishMul();
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL mul_cycles: got %0d want 8", n);
    end
    checks++;
    if (rlast !== 8'h8F || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_result: rlast %h done %b busy %b want 8F 1 0", rlast, done, busy);
    end
    checks++;
    if (flags !== 4'b0100 || flags !== mFlags) begin
      errors++;
      $display("FAIL mul_flags: got %b want 0100", flags);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || rlast !== 8'h8F) begin
      errors++;
      $display("FAIL mul_after: done %b rlast %h want 0 8F", done, rlast);
    end
  endtask

  task automatic test_reset_mid_mul();
    startMul(1, 1, 1, 'h0F, 3, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rmul_busy: got %b want 1", busy);
    end
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    modelReset();
    checks++;
    if (rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        flags !== 4'b0000 || rlast !== 8'h00) begin
      errors++;
      $display("FAIL rmul_state: rdy %b busy %b done %b flags %b rlast %h want 1 0 0 0000 00",
               rdy, busy, done, flags, rlast);
    end
    issue(0, 0, 1, 1, 0, 'h21, 15, 0, 3);
    checks++;
    if (rlast !== 8'h21 || done !== 1'b1 || flags !== mFlags) begin
      errors++;
      $display("FAIL rmul_add: rlast %h done %b want 21 1", rlast, done);
    end
  endtask

  task automatic test_random();
    int o, n;
    bit src;
    for (int it = 0; it < 300; it++) begin
      o = $urandom_range(15);
      src = ($urandom_range(3) == 0);
      if (o == 10 && !src) begin
        startMul(bit'($urandom_range(1)), bit'($urandom_range(1)),
                 bit'($urandom_range(1)), $urandom_range(255),
                 $urandom_range(15), $urandom_range(15), $urandom_range(15));
        waitReady(n);
        finishMul();
        checks++;
        if (n !== 8 || done !== 1'b1) begin
          errors++;
          $display("FAIL rnd_mul: cycles %0d done %b want 8 1", n, done);
        end
      end else begin
        issue(o, src, bit'($urandom_range(1)), bit'($urandom_range(1)),
              bit'($urandom_range(1)), $urandom_range(255),
              $urandom_range(15), $urandom_range(15), $urandom_range(15));
      end
      checks++;
      if (done !== 1'b1 || flags !== mFlags || rlast !== mReg[15][7:0]) begin
        errors++;
        $display("FAIL rnd_%0d op %0d: done %b flags %b rlast %h want 1 %b %h",
                 it, o, done, flags, rlast, mFlags, mReg[15][7:0]);
      end
      if ($urandom_range(4) == 0) begin
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle_%0d: done %b want 0", it, done);
        end
      end
    end
  endtask

  task automatic test_regs();
    int exp;
    for (int r = 0; r < 15; r++) begin
      exp = mReg[r];
      issue(8, 0, 1, 0, 0, 0, 15, r, 0);
      checks++;
      if (rlast !== exp[7:0] || flags !== mFlags) begin
        errors++;
        $display("FAIL regs_r%0d: got %h/%b want %h/%b", r, rlast, flags, exp[7:0], mFlags);
      end
    end
  endtask

  task automatic drive16(input int o, input bit src, input bit we,
                         input bit sa, input bit sb, input int e,
                         input int d, input int ra, input int rb);
    op16 = o[3:0]; src16 = src; we16 = we; ma16 = sa; mb16 = sb;
    ext16 = e[15:0]; d16 = d[3:0]; a16 = ra[3:0]; b16 = rb[3:0];
    v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
  endtask

  task automatic test_wide();
    longint r;
    logic [3:0] f;
    int n;
    rst16 = 1'b1;
    @(posedge clk); #1;
    rst16 = 1'b0;
    checks++;
    if (rdy16 !== 1'b1 || busy16 !== 1'b0 || rl16 !== 16'h0 || fl16 !== 4'b0) begin
      errors++;
      $display("FAIL w_reset: rdy %b busy %b rlast %h flags %b", rdy16, busy16, rl16, fl16);
    end
    drive16(0, 1, 1, 0, 0, 'h1234, 13, 0, 0);
    checks++;
    if (done16 !== 1'b1 || fl16 !== 4'b0000) begin
      errors++;
      $display("FAIL w_oob_write: done %b flags %b want 1 0000", done16, fl16);
    end
    drive16(8, 0, 1, 0, 0, 0, 11, 13, 0);
    checks++;
    if (rl16 !== 16'h0000 || fl16 !== 4'b1000) begin
      errors++;
      $display("FAIL w_oob_read: rlast %h flags %b want 0000 1000", rl16, fl16);
    end
    drive16(0, 1, 1, 0, 0, 'hFFFF, 1, 0, 0);
    refAlu(16, 0, 'hFFFF, 1, r, f);
    drive16(0, 0, 1, 0, 1, 1, 11, 1, 0);
    checks++;
    if (rl16 !== r[15:0] || fl16 !== f || fl16 !== 4'b1010) begin
      errors++;
      $display("FAIL w_wrap: rlast %h flags %b want %h %b", rl16, fl16, r[15:0], f);
    end
    refAlu(16, 10, 'h0101, 'h0101, r, f);
    drive16(10, 0, 1, 1, 1, 'h0101, 11, 0, 0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rdy16 && n < 60);
    checks++;
    if (n !== 16 || rl16 !== r[15:0] || fl16 !== f || done16 !== 1'b1) begin
      errors++;
      $display("FAIL w_mul: cycles %0d rlast %h flags %b want 16 %h %b",
               n, rl16, fl16, r[15:0], f);
    end
  endtask

  initial begin
    rst8 = 1'b1; valid = 1'b0; wEn = 1'b0; wSrc = 1'b0;
    mA = 1'b0; mB = 1'b0; ext = '0; dest = '0; aAd = '0; bAd = '0; op = '0;
    rst16 = 1'b1; v16 = 1'b0; we16 = 1'b0; src16 = 1'b0;
    ma16 = 1'b0; mb16 = 1'b0; ext16 = '0; d16 = '0; a16 = '0; b16 = '0; op16 = '0;
    modelReset();
    pRes = 0; pDest = 0; pWe = 1'b0; pFlags = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_loads();
    test_arith();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    test_random();
    test_regs();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/param_datapath.md
Name: param_datapath

Overview:
- Parametrised next-generation datapath: NUM_REGS x DATA_W register file, operand muxes, ALU with a registered status-flag word (Z,N,C,V), and a valid/ready instruction handshake.
- Single-cycle ops retire on the accepting edge.
- MUL is a multi-cycle iterative shift-add op; a small FSM stalls the handshake while it runs.
- Sits between the control unit / instruction sequencer and the I/O register monitor; the last register (R[NUM_REGS-1]) is always exposed.

Parameters:
- DATA_W, 8: datapath and register width in bits, >= 4.
- NUM_REGS, 16: number of registers, 2..2^ADDR_W.
- ADDR_W, 4: register address width; 2^ADDR_W >= NUM_REGS is required.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inValid  in  1  instruction fields valid this cycle.
- inReady  out  1  block can accept an instruction; accept = inValid & inReady at a rising edge.
- writeEnable  in  1  write the result to R[destAddress].
- writeSourceSelect  in  1  1: write extInputData; 0: write ALU result.
- muxASelect  in  1  ALU A operand = extInputData (1) or R[aAddress] (0).
- muxBSelect  in  1  ALU B operand = extInputData (1) or R[bAddress] (0).
- extInputData  in  DATA_W  immediate / external data.
- destAddress  in  ADDR_W  write register address.
- aAddress  in  ADDR_W  A read address.
- bAddress  in  ADDR_W  B read address.
- aluOpCode  in  4  operation select.
- busy  out  1  MUL in progress.
- done  out  1  one-cycle pulse: an accepted instruction has retired.
- flags  out  4  {Z,N,C,V}, registered.
- RLast_out  out  DATA_W  current value of R[NUM_REGS-1].

Behaviour:
- Reset (rst=1 at an edge):
  - All registers, flags and done go to 0; busy goes to 0; inReady goes to 1; FSM goes to IDLE.
  - Reset during MUL aborts it: no write and no flag update occur.
- Register file reads:
  - Reads are combinational.
  - Writes are registered, so a read of the register being written in the same cycle returns the old value.
  - Addresses >= NUM_REGS read as 0; writes to them are dropped.
- Opcodes (A, B are DATA_W-bit mux outputs):
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SHL A by 1, 7 SHR A (logical) by 1.
  - 8 PASS A, 9 PASS B, 10 MUL (low DATA_W bits of A*B), 11 INC A, 12 DEC A.
  - 13-15 reserved: result 0.
- Flags:
  - Flags update only when an ALU-sourced instruction retires (writeSourceSelect=0), independent of writeEnable.
  - Z = result==0; N = result MSB.
  - ADD/INC: C = carry-out; V = signed overflow.
  - SUB/DEC: C = borrow (1 when A < subtrahend, unsigned); V = signed overflow.
  - SHL: C = A[DATA_W-1]; SHR: C = A[0]; V=0 for both.
  - All other ops: C=0, V=0.
  - External loads (writeSourceSelect=1) leave flags unchanged.
- FSM states IDLE and MUL.
- IDLE, single-cycle instruction accepted at edge T (any op with writeSourceSelect=1, or a non-MUL ALU op):
  - Register write and flag update happen at edge T.
  - done=1 during cycle T..T+1; inReady stays 1, so back-to-back accepts are allowed every cycle.
- IDLE, MUL accepted at edge T (opcode 10, writeSourceSelect=0):
  - Latch A, B, destAddress and writeEnable.
  - Enter MUL: busy=1, inReady=0.
  - One multiplier bit is processed per cycle, so DATA_W iterations.
  - At edge T+DATA_W: result written (if latched writeEnable=1), flags updated, return to IDLE; busy=0 and inReady=1 after that edge.
  - done pulses for the one cycle following edge T+DATA_W.
  - Any inValid during MUL is ignored (not accepted and not queued).
- Width rules:
  - All arithmetic is modulo 2^DATA_W.
  - The upper half of the MUL product is discarded and does not affect flags.
- inValid=0 at an edge: no state change except done returning to 0.

Test Plan:
1. Reset, then load R1=0x7F and R2=0x01 via writeSourceSelect=1 -> RLast_out=0, flags=0000, done pulses once per load.
2. ADD R3=R1+R2 (DATA_W=8) -> R3=0x80, flags Z=0 N=1 C=0 V=1; SUB R4=R2-R1 -> 0x82, C=1, N=1, V=0.
3. Back-to-back: write R15=0x55 at edge T, then read A=R15 PASS into R5 at edge T+1 -> R5=0x55; same-cycle read of R15 during its write returns the old value.
4. MUL 0x0D*0x0B into R15 (DATA_W=8) -> inReady low for exactly 8 cycles; RLast_out=0x8F at edge T+8; C=V=0; an inValid pulse mid-MUL is ignored.
5. Assert rst at cycle 4 of a MUL -> no write to dest, all regs 0, inReady=1 the next cycle; a subsequent ADD retires normally.
6. Rerun with DATA_W=16, NUM_REGS=12, ADDR_W=4 -> write to address 13 is dropped and reads 0; 0xFFFF+1 gives 0x0000 with Z=1, C=1.
